// File: rtl/smac_engine_ctrl.sv
// smac_engine_ctrl: sequencing controller for a streaming MAC engine.
// Per output tile it walks n_in activation packets. For each activation it
// accepts n_wei weight packets, one MAC enable per weight, then waits
// MAC_LAT cycles for the MAC pipeline to drain. After the last activation
// of a tile it writes the result back and starts the next tile. It never
// stops by itself: only clear_i or rst_ni return it to IDLE.
//
// Handshakes: a transfer happens in a cycle where both valid and ready are
// high at the rising clock edge. act_ready_o, wei_ready_o and out_valid_o
// depend on the state only, never on the matching valid/ready input, so
// they hold steady across a stall.
module smac_engine_ctrl #(
   parameter int CNT_W   = 16,
   parameter int WEI_W   = 8,
   parameter int MAC_LAT = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] n_in_i,
   input  logic [WEI_W-1:0] n_wei_i,
   input  logic             act_valid_i,
   output logic             act_ready_o,
   input  logic             wei_valid_i,
   output logic             wei_ready_o,
   output logic             mac_en_o,
   output logic             acc_clear_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             update_in_o,
   output logic             update_out_o,
   output logic             busy_o,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD_ACT = 3'd1,
      COMPUTE  = 3'd2,
      DRAIN    = 3'd3,
      UPD_IN   = 3'd4,
      WRITE    = 3'd5,
      UPD_OUT  = 3'd6
   } state_e;

   // The drain counter counts down from MAC_LAT-1 to 0, so DRAIN lasts
   // exactly MAC_LAT cycles.
   localparam logic [3:0] LAT_INIT = 4'(MAC_LAT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] n_in_q, n_in_d;
   logic [WEI_W-1:0] n_wei_q, n_wei_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
   logic [WEI_W-1:0] wei_cnt_q, wei_cnt_d;
   logic [3:0]       lat_q, lat_d;

   // State, latched configuration and counters; reset and clear zero everything.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state_q   <= IDLE;
         n_in_q    <= '0;
         n_wei_q   <= '0;
         in_cnt_q  <= '0;
         wei_cnt_q <= '0;
         lat_q     <= '0;
      end else begin
         state_q   <= state_d;
         n_in_q    <= n_in_d;
         n_wei_q   <= n_wei_d;
         in_cnt_q  <= in_cnt_d;
         wei_cnt_q <= wei_cnt_d;
         lat_q     <= lat_d;
      end
   end

   // Next-state, counter updates and state-decoded outputs.
   always_comb begin
      state_d      = state_q;
      n_in_d       = n_in_q;
      n_wei_d      = n_wei_q;
      in_cnt_d     = in_cnt_q;
      wei_cnt_d    = wei_cnt_q;
      lat_d        = lat_q;
      act_ready_o  = 1'b0;
      wei_ready_o  = 1'b0;
      acc_clear_o  = 1'b0;
      out_valid_o  = 1'b0;
      update_in_o  = 1'b0;
      update_out_o = 1'b0;

      case (state_q)
         IDLE: begin
            acc_clear_o = 1'b1;
            if (start_i) begin
               // A zero count would never terminate the loop; run it as one.
               n_in_d    = (n_in_i == '0) ? CNT_W'(1) : n_in_i;
               n_wei_d   = (n_wei_i == '0) ? WEI_W'(1) : n_wei_i;
               in_cnt_d  = '0;
               wei_cnt_d = '0;
               state_d   = LOAD_ACT;
            end
         end
         LOAD_ACT: begin
            act_ready_o = 1'b1;
            if (act_valid_i) begin
               wei_cnt_d = '0;
               state_d   = COMPUTE;
            end
         end
         COMPUTE: begin
            wei_ready_o = 1'b1;
            if (wei_valid_i) begin
               wei_cnt_d = wei_cnt_q + WEI_W'(1);
               if (wei_cnt_q == n_wei_q - WEI_W'(1)) begin
                  lat_d   = LAT_INIT;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (lat_q == 4'd0) begin
               if (in_cnt_q == n_in_q - CNT_W'(1)) begin
                  state_d = WRITE;
               end else begin
                  in_cnt_d = in_cnt_q + CNT_W'(1);
                  state_d  = UPD_IN;
               end
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         UPD_IN: begin
            update_in_o = 1'b1;
            state_d     = LOAD_ACT;
         end
         WRITE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_d = UPD_OUT;
            end
         end
         UPD_OUT: begin
            update_out_o = 1'b1;
            acc_clear_o  = 1'b1;
            in_cnt_d     = '0;
            state_d      = LOAD_ACT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The MAC enable is the weight handshake itself.
   assign mac_en_o = wei_valid_i & wei_ready_o;
   assign busy_o   = (state_q != IDLE);
   assign state_o  = state_q;

endmodule
